register_file_np: RTL and testbench
===================================

# register_file_np

Parametrised multi-entry register file with one write port and two asynchronous read ports (RS, RT). It generalises data width and depth, and optionally hardwires entry 0 to zero. A built-in sequential clear engine zeroes every entry after reset and holds off writes until clearing completes. It sits in the datapath between decode (RS/RT/RD fields) and the ALU/writeback stage.

## Interface
- DATA_W, 32, width of each entry and of dataRD/dataRS/dataRT
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register
- Clk  in  1  single clock; all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- RW  in  1  write enable
- RD  in  ADDR_W  write address
- dataRD  in  DATA_W  write data
- RS  in  ADDR_W  read address, port S
- RT  in  ADDR_W  read address, port T
- dataRS  out  DATA_W  read data, port S (combinational)
- dataRT  out  DATA_W  read data, port T (combinational)
- Ready  out  1  1 = clear finished, writes accepted

## Operation
- States: CLEAR, READY.
- Rst high at an edge: state <= CLEAR, clr_cnt <= 0, Ready <= 0. This also applies mid-clear and while READY; an in-flight write on that edge is dropped.
- CLEAR, Rst low: each edge writes 0 to entry clr_cnt, then clr_cnt <= clr_cnt+1. The edge that clears entry DEPTH-1 moves to READY (Ready <= 1). clr_cnt is ADDR_W+1 bits wide with no wrap.
- CLEAR: RW ignored; dataRS/dataRT forced to 0 regardless of array contents.
- READY: on an edge with RW=1, entry RD <= dataRD. The exception is RD=0 with ZERO_REG=1, which leaves the array unchanged.
- Reads: dataRS = entry[RS], dataRT = entry[RT]. RS=RT is legal; both ports return the same value.
- ZERO_REG=1: reads of address 0 return 0 in every state.
- No out-of-range addresses exist; the full 2**ADDR_W space is implemented.

## Timing
- Reset values: Ready=0, dataRS=0, dataRT=0, state=CLEAR, clr_cnt=0.
- Clear latency: Ready rises DEPTH edges after the first edge with Rst low. Default is 32 edges.
- Write latency: a value written at edge N is visible on read ports after edge N. Same-cycle read-during-write behaviour depends on REGFILE_BYPASS_EN.
- Read latency: combinational from RS/RT and array contents; no pipeline register.
- The write and any read of a different address in the same cycle are independent.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In READY, if RW=1 and RS (or RT) equals RD, the matching read port returns dataRD in the same cycle (write-first).
  - Bypass is suppressed when ZERO_REG=1 and RD=0; the port still reads 0.
- Not defined: reads always return the array content before the edge (read-first). This is the old value during a same-address write.

## Structure
- Package regfile_pkg holds:
  - the state type (CLEAR, READY);
  - default constants DATA_W_DEF=32 and ADDR_W_DEF=5.
- Sub-module regfile_clear_ctrl holds the CLEAR/READY FSM and clr_cnt.
  - Outputs: Ready, clr_we, clr_addr.
- The top holds:
  - the storage array;
  - the write-port mux (clear vs. user write);
  - the read muxes and the bypass logic.

## Test plan
- Clear sequence: Rst high 2 edges, then low.
  - Ready=0 for exactly 32 edges, then 1.
  - All 32 entries read 0.
  - RW=1, RD=5, dataRD=0xDEADBEEF during CLEAR is not stored; entry 5 still reads 0.
- Basic write/read: in READY, write 0x12345678 to RD=7, then RS=7 and RT=7.
  - Both ports return 0x12345678 after the edge.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to RD=0.
  - RS=0 returns 0.
  - Repeat with ZERO_REG=0: returns 0xFFFFFFFF.
- Same-cycle hazard: entry 3 holds 0xA, with RW=1, RD=3, dataRD=0xB, RS=3 in the same cycle.
  - With REGFILE_BYPASS_EN: dataRS=0xB before the edge.
  - Without it: dataRS=0xA.
  - After the edge, both builds read 0xB.
- Reset mid-operation:
  - Assert Rst at clear step 10: the clear restarts and Ready rises 32 edges after Rst falls.
  - Assert Rst in READY after writing 0x55 to RD=9: the entry reads 0 once Ready returns.
- Parametrisation: DATA_W=16, ADDR_W=3.
  - Ready after 8 edges.
  - Write 0xBEEF to RD=7; RT=7 returns 0xBEEF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register file and its clear engine.
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } regfile_state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Sequential clear engine: walks every entry after reset, writing zero, then
// raises Ready. The counter is one bit wider than the address so it never wraps.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic              Ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int            DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  regfile_state_e    state_r;
  regfile_state_e    state_nxt_s;
  logic [ADDR_W:0]   clr_cnt_r;
  logic [ADDR_W:0]   clr_cnt_nxt_s;
  logic              ready_nxt_s;

  // State, counter and Ready registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r   <= CLEAR;
      clr_cnt_r <= '0;
      Ready     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
      Ready     <= ready_nxt_s;
    end
  end

  // Next-state logic: step through entries, leave CLEAR after the last one.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    ready_nxt_s   = 1'b0;
    case (state_r)
      CLEAR: begin
        clr_cnt_nxt_s = clr_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
        if (clr_cnt_r == LAST_IDX) begin
          state_nxt_s = READY;
          ready_nxt_s = 1'b1;
        end else begin
          state_nxt_s = CLEAR;
          ready_nxt_s = 1'b0;
        end
      end
      READY: begin
        state_nxt_s = READY;
        ready_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s   = CLEAR;
        clr_cnt_nxt_s = '0;
        ready_nxt_s   = 1'b0;
      end
    endcase
  end

  // A reset edge must not also clear an entry, so the strobe is gated by Rst.
  assign clr_we   = (state_r == CLEAR) && !Rst;
  assign clr_addr = clr_cnt_r[ADDR_W-1:0];

endmodule

// File: rtl/register_file_np.sv
// Parametrised register file: one write port, two combinational read ports,
// optional hardwired-zero entry 0. Define REGFILE_BYPASS_EN for write-first reads.
module register_file_np
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RW,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] dataRD,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  output logic [DATA_W-1:0] dataRS,
  output logic [DATA_W-1:0] dataRT,
  output logic              Ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              usr_we_s;
  logic [DATA_W-1:0] data_rs_s;
  logic [DATA_W-1:0] data_rt_s;

  regfile_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .Clk      (Clk),
    .Rst      (Rst),
    .Ready    (Ready),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  assign usr_we_s = Ready && RW && !Rst && !(ZERO_REG && (RD == '0));

  // Storage write port: the clear engine owns the array until Ready.
  always_ff @(posedge Clk) begin
    if (clr_we_s) begin
      mem_r[clr_addr_s] <= '0;
    end else if (usr_we_s) begin
      mem_r[RD] <= dataRD;
    end
  end

  // Read port S: zero while clearing and for the hardwired entry.
  always_comb begin
    data_rs_s = '0;
    if (!Ready) begin
      data_rs_s = '0;
    end else if (ZERO_REG && (RS == '0)) begin
      data_rs_s = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (RW && (RS == RD)) begin
      data_rs_s = dataRD;
`endif
    end else begin
      data_rs_s = mem_r[RS];
    end
  end

  // Read port T: same rules as port S.
  always_comb begin
    data_rt_s = '0;
    if (!Ready) begin
      data_rt_s = '0;
    end else if (ZERO_REG && (RT == '0)) begin
      data_rt_s = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (RW && (RT == RD)) begin
      data_rt_s = dataRD;
`endif
    end else begin
      data_rt_s = mem_r[RT];
    end
  end

  assign dataRS = data_rs_s;
  assign dataRT = data_rt_s;

endmodule

// File: tb/tb_register_file_np.sv
// Directed self-checking bench: two 32x32 instances (ZERO_REG=1/0) sharing
// stimulus, plus an 8x16 instance for parametrisation.
module tb_register_file_np;

  logic        Clk;
  logic        rst;
  logic        rw;
  logic [4:0]  rd;
  logic [31:0] data_rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rs_z, rt_z, rs_n, rt_n;
  logic        ready_z, ready_n;

  logic        rst2;
  logic        rw2;
  logic [2:0]  rd2;
  logic [15:0] data_rd2;
  logic [2:0]  rs2;
  logic [2:0]  rt2;
  logic [15:0] ds2, dt2;
  logic        ready2;

  int checks;
  int failures;

  register_file_np #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut_z (
    .Clk(Clk), .Rst(rst), .RW(rw), .RD(rd), .dataRD(data_rd), .RS(rs), .RT(rt),
    .dataRS(rs_z), .dataRT(rt_z), .Ready(ready_z)
  );

  register_file_np #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut_n (
    .Clk(Clk), .Rst(rst), .RW(rw), .RD(rd), .dataRD(data_rd), .RS(rs), .RT(rt),
    .dataRS(rs_n), .dataRT(rt_n), .Ready(ready_n)
  );

  register_file_np #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) dut_s (
    .Clk(Clk), .Rst(rst2), .RW(rw2), .RD(rd2), .dataRD(data_rd2), .RS(rs2), .RT(rt2),
    .dataRS(ds2), .dataRT(dt2), .Ready(ready2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_clear();
    int edge_z;
    int edge_n;
    int edge_s;
    rst = 1'b1; rst2 = 1'b1;
    tick(); tick();
    checks++;
    if (ready_z !== 1'b0 || rs_z !== 32'h0 || rt_z !== 32'h0) begin
      failures++;
      $display("FAIL reset_state ready=%b rs=%h rt=%h expected ready=0 rs=0 rt=0", ready_z, rs_z, rt_z);
    end
    rst = 1'b0; rst2 = 1'b0;
    rw = 1'b1; rd = 5'd5; data_rd = 32'hDEADBEEF;
    edge_z = 0; edge_n = 0; edge_s = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready_s_first(ready2, edge_s)) edge_s = i;
      if (ready_n && edge_n == 0) edge_n = i;
      if (ready_z) begin
        edge_z = i;
        break;
      end
    end
    rw = 1'b0;
    checks++;
    if (edge_z !== 32) begin
      failures++;
      $display("FAIL clear_latency_z edges=%0d expected 32", edge_z);
    end
    checks++;
    if (edge_n !== 32) begin
      failures++;
      $display("FAIL clear_latency_n edges=%0d expected 32", edge_n);
    end
    checks++;
    if (edge_s !== 8) begin
      failures++;
      $display("FAIL clear_latency_small edges=%0d expected 8", edge_s);
    end
    for (int a = 0; a < 32; a++) begin
      rs = 5'(a); rt = 5'(31 - a);
      #1;
      checks++;
      if (rs_n !== 32'h0 || rt_n !== 32'h0 || rs_z !== 32'h0) begin
        failures++;
        $display("FAIL cleared_entry addr=%0d rs=%h rt=%h expected 0", a, rs_n, rt_n);
      end
    end
    rs = 5'd5;
    #1;
    checks++;
    if (rs_z !== 32'h0 || rs_n !== 32'h0) begin
      failures++;
      $display("FAIL write_during_clear rs=%h expected 0", rs_z);
    end
  endtask

  function automatic bit ready_s_first(input logic r, input int e);
    return (r === 1'b1) && (e == 0);
  endfunction

  task automatic test_basic_rw();
    rw = 1'b1; rd = 5'd7; data_rd = 32'h12345678;
    tick();
    rw = 1'b0; rs = 5'd7; rt = 5'd7;
    #1;
    checks++;
    if (rs_z !== 32'h12345678 || rt_z !== 32'h12345678) begin
      failures++;
      $display("FAIL basic_rw rs=%h rt=%h expected 12345678", rs_z, rt_z);
    end
    checks++;
    if (rs_n !== 32'h12345678) begin
      failures++;
      $display("FAIL basic_rw_n rs=%h expected 12345678", rs_n);
    end
  endtask

  task automatic test_zero_reg();
    rw = 1'b1; rd = 5'd0; data_rd = 32'hFFFFFFFF;
    tick();
    rw = 1'b0; rs = 5'd0; rt = 5'd0;
    #1;
    checks++;
    if (rs_z !== 32'h0 || rt_z !== 32'h0) begin
      failures++;
      $display("FAIL zero_reg_on rs=%h rt=%h expected 0", rs_z, rt_z);
    end
    checks++;
    if (rs_n !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL zero_reg_off rs=%h expected ffffffff", rs_n);
    end
    rw = 1'b1; rd = 5'd0; data_rd = 32'h00000077; rs = 5'd0;
    #1;
    checks++;
    if (rs_z !== 32'h0) begin
      failures++;
      $display("FAIL zero_reg_bypass rs=%h expected 0", rs_z);
    end
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (rs_n !== 32'h00000077) begin
      failures++;
      $display("FAIL bypass_reg0_off rs=%h expected 00000077", rs_n);
    end
`else
    if (rs_n !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL bypass_reg0_off rs=%h expected ffffffff", rs_n);
    end
`endif
    rw = 1'b0;
  endtask

  task automatic test_hazard();
    rw = 1'b1; rd = 5'd3; data_rd = 32'h0000000A;
    tick();
    data_rd = 32'h0000000B; rs = 5'd3; rt = 5'd4;
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (rs_z !== 32'h0000000B) begin
      failures++;
      $display("FAIL hazard_same_cycle rs=%h expected 0000000b", rs_z);
    end
`else
    if (rs_z !== 32'h0000000A) begin
      failures++;
      $display("FAIL hazard_same_cycle rs=%h expected 0000000a", rs_z);
    end
`endif
    checks++;
    if (rt_z !== 32'h0) begin
      failures++;
      $display("FAIL hazard_other_port rt=%h expected 0", rt_z);
    end
    tick();
    rw = 1'b0;
    #1;
    checks++;
    if (rs_z !== 32'h0000000B || rs_n !== 32'h0000000B) begin
      failures++;
      $display("FAIL hazard_after_edge rs=%h expected 0000000b", rs_z);
    end
  endtask

  task automatic test_reset_mid_clear();
    int edges;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready_z) begin
        edges = i;
        break;
      end
    end
    checks++;
    if (edges !== 32) begin
      failures++;
      $display("FAIL reset_mid_clear edges=%0d expected 32", edges);
    end
  endtask

  task automatic test_reset_ready();
    int edges;
    rw = 1'b1; rd = 5'd9; data_rd = 32'h00000055;
    tick();
    rw = 1'b0; rs = 5'd9;
    #1;
    checks++;
    if (rs_z !== 32'h00000055) begin
      failures++;
      $display("FAIL pre_reset_write rs=%h expected 00000055", rs_z);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (ready_z !== 1'b0 || rs_z !== 32'h0) begin
      failures++;
      $display("FAIL reset_in_ready ready=%b rs=%h expected ready=0 rs=0", ready_z, rs_z);
    end
    rst = 1'b0;
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready_z) begin
        edges = i;
        break;
      end
    end
    checks++;
    if (edges !== 32 || rs_z !== 32'h0) begin
      failures++;
      $display("FAIL reset_ready_clear edges=%0d rs=%h expected 32 and 0", edges, rs_z);
    end
  endtask

  task automatic test_param();
    rw2 = 1'b1; rd2 = 3'd7; data_rd2 = 16'hBEEF;
    tick();
    rw2 = 1'b0; rt2 = 3'd7; rs2 = 3'd0;
    #1;
    checks++;
    if (dt2 !== 16'hBEEF) begin
      failures++;
      $display("FAIL param_write rt=%h expected beef", dt2);
    end
    checks++;
    if (ds2 !== 16'h0) begin
      failures++;
      $display("FAIL param_zero rs=%h expected 0", ds2);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; rw = 1'b0; rd = 5'd0; data_rd = 32'h0; rs = 5'd0; rt = 5'd0;
    rst2 = 1'b1; rw2 = 1'b0; rd2 = 3'd0; data_rd2 = 16'h0; rs2 = 3'd0; rt2 = 3'd0;
    test_clear();
    test_basic_rw();
    test_zero_reg();
    test_hazard();
    test_param();
    test_reset_mid_clear();
    test_reset_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
